// File: rtl/rotate_shift_pipe_if.sv
// Operand/result handshake bundle for rotate_shift_pipe.
// The master drives operands and consumes results; the slave is the pipeline.
interface rotate_shift_pipe_if #(
   parameter int unsigned WIDTH = 8
) ();
   localparam int unsigned SW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SW-1:0]    in_shamt;
   logic [1:0]       in_mode;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic [1:0]       out_mode;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_mode
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_mode
   );
endinterface

// File: rtl/rotate_shift_pipe.sv
// Pipelined barrel rotator/shifter: stage k applies a shift of 2^k when shamt bit k is set.
// ROL/ROR/SHL/SAR modes, valid/ready on both sides with a combinational ready chain.
module rotate_shift_pipe #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned SW    = $clog2(WIDTH)
) (
   input logic               clk,
   input logic               rst_n,
   rotate_shift_pipe_if.slave io
);
   localparam logic [1:0] MODE_ROL = 2'b00;
   localparam logic [1:0] MODE_ROR = 2'b01;
   localparam logic [1:0] MODE_SHL = 2'b10;

   if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("rotate_shift_pipe: WIDTH must be a power of two and at least 4");
   end

   // One shift step; SAR replicates the current MSB so the sign survives every stage.
   function automatic logic [WIDTH-1:0] stage_shift(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       mode,
      input logic             en,
      input int unsigned      amt
   );
      logic [WIDTH-1:0] r;
      r = d;
      if (en) begin
         case (mode)
            MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
            MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
            MODE_SHL: r = d << amt;
            default:  r = WIDTH'($signed(d) >>> amt);
         endcase
      end
      return r;
   endfunction

   logic [SW-1:0]             valid_q;
   logic [SW-1:0][WIDTH-1:0]  data_q;
   logic [SW-1:0][1:0]        mode_q;
   logic [SW-2:0][SW-1:0]     shamt_q;
   logic                      zero_q;

   logic [SW-1:0]             ready;
   logic [SW-1:0]             src_valid;
   logic [SW-1:0][WIDTH-1:0]  src_data;
   logic [SW-1:0][1:0]        src_mode;
   logic [SW-1:0][SW-1:0]     src_shamt;
   logic [SW-1:0][WIDTH-1:0]  shifted;

   // Ready ripples back from the output: a stage can take a beat if empty or draining.
   always_comb begin
      logic chain;
      chain = io.out_ready;
      ready = '0;
      for (int k = int'(SW) - 1; k >= 0; k--) begin
         chain    = ~valid_q[k] | chain;
         ready[k] = chain;
      end
   end

   // Upstream view of each stage: the input port for stage 0, the previous register otherwise.
   always_comb begin
      src_valid    = '0;
      src_data     = '0;
      src_mode     = '0;
      src_shamt    = '0;
      src_valid[0] = io.in_valid;
      src_data[0]  = io.in_data;
      src_mode[0]  = io.in_mode;
      src_shamt[0] = io.in_shamt;
      for (int k = 1; k < int'(SW); k++) begin
         src_valid[k] = valid_q[k-1];
         src_data[k]  = data_q[k-1];
         src_mode[k]  = mode_q[k-1];
         src_shamt[k] = shamt_q[k-1];
      end
   end

   // The shamt carried forward is pre-shifted so each stage always tests bit 0.
   always_comb begin
      shifted = '0;
      for (int k = 0; k < int'(SW); k++) begin
         shifted[k] = stage_shift(src_data[k], src_mode[k], src_shamt[k][0], 32'd1 << k);
      end
   end

   // Payload only moves with a valid beat, so bubbles never disturb held data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         mode_q  <= '0;
         shamt_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         for (int k = 0; k < int'(SW); k++) begin
            if (ready[k]) begin
               valid_q[k] <= src_valid[k];
               if (src_valid[k]) begin
                  data_q[k] <= shifted[k];
                  mode_q[k] <= src_mode[k];
               end
            end
         end
         for (int k = 0; k < int'(SW) - 1; k++) begin
            if (ready[k] && src_valid[k]) begin
               shamt_q[k] <= src_shamt[k] >> 1;
            end
         end
         if (ready[SW-1] && src_valid[SW-1]) begin
            zero_q <= (shifted[SW-1] == '0);
         end
      end
   end

   assign io.in_ready  = ready[0];
   assign io.out_valid = valid_q[SW-1];
   assign io.out_data  = data_q[SW-1];
   assign io.out_mode  = mode_q[SW-1];
   assign io.out_zero  = zero_q;

   // A stalled result must not change underneath the consumer.
   out_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
      (io.out_valid && !io.out_ready) |=>
         (io.out_valid && $stable(io.out_data) && $stable(io.out_mode) && $stable(io.out_zero)));
endmodule

// File: tb/tb_rotate_shift_pipe.sv
// Scoreboard bench for rotate_shift_pipe (WIDTH=8): directed vectors, stall, random
// back-pressure and mid-flight reset, checked against a bit-level reference model.
module tb_rotate_shift_pipe;
   localparam int unsigned WIDTH = 8;

   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      logic       zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rotate_shift_pipe_if #(.WIDTH(WIDTH)) io ();

   rotate_shift_pipe #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   exp_t sb[$];
   int   checks     = 0;
   int   failures   = 0;
   int   in_count   = 0;
   int   out_count  = 0;
   bit   rand_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each result bit is picked directly from its source position.
   function automatic logic [7:0] ref_model(input logic [7:0] d, input logic [2:0] s,
                                            input logic [1:0] m);
      logic [7:0] r;
      int sh;
      sh = int'(s);
      for (int i = 0; i < 8; i++) begin
         case (m)
            2'b00:   r[i] = d[(i - sh + 8) % 8];
            2'b01:   r[i] = d[(i + sh) % 8];
            2'b10:   r[i] = (i >= sh) ? d[i - sh] : 1'b0;
            default: r[i] = (i + sh < 8) ? d[i + sh] : d[7];
         endcase
      end
      return r;
   endfunction

   // Called just after a rising edge; returns just after the edge that took the beat.
   task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                       input logic [7:0] e);
      bit accepted;
      int t;
      exp_t x;
      accepted    = 1'b0;
      t           = 0;
      io.in_valid = 1'b1;
      io.in_data  = d;
      io.in_shamt = s;
      io.in_mode  = m;
      while (!accepted && t < 500) begin
         @(negedge clk);
         if (io.in_ready) begin
            x.data = e;
            x.mode = m;
            x.zero = (e == 8'h00);
            sb.push_back(x);
            in_count++;
            accepted = 1'b1;
         end
         @(posedge clk);
         #1;
         t++;
      end
      if (!accepted) begin
         checks++;
         failures++;
         $display("FAIL send_timeout in_ready stuck at 0, required 1 within 500 cycles");
      end
   endtask

   task automatic send_rand(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
      send(d, s, m, ref_model(d, s, m));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops on every output transfer and checks that stalled results hold.
   logic [7:0] held_data;
   logic [1:0] held_mode;
   bit         was_stalled = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         was_stalled = 1'b0;
      end else begin
         if (was_stalled) begin
            chk("stall_valid", io.out_valid, 1);
            chk("stall_data", io.out_data, held_data);
            chk("stall_mode", io.out_mode, held_mode);
         end
         if (io.out_valid && io.out_ready) begin
            out_count++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output data=0x%0h required no output", io.out_data);
            end else begin
               e = sb.pop_front();
               chk("out_data", io.out_data, e.data);
               chk("out_mode", io.out_mode, e.mode);
               chk("out_zero", io.out_zero, e.zero);
            end
         end
         was_stalled = io.out_valid && !io.out_ready;
         held_data   = io.out_data;
         held_mode   = io.out_mode;
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         io.out_ready = ($urandom_range(0, 99) < 60);
      end
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int base_in;
      int base_out;
      logic [7:0] d;
      io.in_valid  = 1'b0;
      io.in_data   = 8'hA5;
      io.in_shamt  = 3'd5;
      io.in_mode   = 2'b11;
      io.out_ready = 1'b0;
      rst_n        = 1'b1;
      #2 rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", io.out_valid, 0);
      chk("rst_out_data", io.out_data, 0);
      chk("rst_out_zero", io.out_zero, 0);
      chk("rst_out_mode", io.out_mode, 0);
      chk("rst_in_ready", io.in_ready, 1);
      rst_n = 1'b1;

      // Idle with junk on the operand lines
      repeat (4) begin
         @(negedge clk);
         chk("idle_out_valid", io.out_valid, 0);
         chk("idle_out_data", io.out_data, 0);
      end
      @(posedge clk);
      #1;
      io.out_ready = 1'b1;

      // Back-to-back ROL/ROR with latency check
      send(8'h81, 3'd1, 2'b00, 8'h03);
      send(8'h01, 3'd3, 2'b01, 8'h20);
      io.in_valid = 1'b0;
      @(negedge clk);
      chk("lat_pre_valid", io.out_valid, 0);
      @(negedge clk);
      chk("lat_first_valid", io.out_valid, 1);
      chk("lat_first_data", io.out_data, 8'h03);
      @(negedge clk);
      chk("b2b_second_valid", io.out_valid, 1);
      chk("b2b_second_data", io.out_data, 8'h20);
      @(posedge clk);
      #1;
      drain();

      // Fill patterns, sign propagation, zero flag, amount 0
      send(8'hFF, 3'd4, 2'b10, 8'hF0);
      send(8'h80, 3'd7, 2'b11, 8'hFF);
      send(8'h7F, 3'd7, 2'b11, 8'h00);
      send(8'h01, 3'd0, 2'b10, 8'h01);
      io.in_valid = 1'b0;
      drain();

      // Eight beats into a stalled output for five cycles
      io.out_ready = 1'b0;
      base_in      = in_count;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               send_rand(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            end
            io.in_valid = 1'b0;
         end
         begin
            repeat (4) @(negedge clk);
            chk("stall_in_ready", io.in_ready, 0);
            chk("stall_accepted", in_count - base_in, 3);
            chk("stall_full_valid", io.out_valid, 1);
            @(negedge clk);
            chk("stall_in_ready2", io.in_ready, 0);
            @(posedge clk);
            #1;
            base_out     = out_count;
            io.out_ready = 1'b1;
            repeat (8) @(negedge clk);
            #1;
            chk("release_rate", out_count - base_out, 8);
         end
      join
      drain();

      // Random traffic under random back-pressure, every mode/amount pair covered
      rand_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            io.in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         d = 8'($urandom);
         if (i % 16 == 5) d = 8'h00;
         send_rand(d, 3'((i / 4) % 8), 2'(i % 4));
      end
      io.in_valid = 1'b0;
      rand_ready  = 1'b0;
      @(posedge clk);
      #2;
      io.out_ready = 1'b1;
      drain();
      chk("count_in_eq_out", out_count, in_count);

      // Reset with three beats in flight
      io.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_rand(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      end
      io.in_valid = 1'b0;
      chk("pre_rst_valid", io.out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", io.out_valid, 0);
      chk("mid_rst_in_ready", io.in_ready, 1);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      io.out_ready = 1'b1;
      base_out     = out_count;
      repeat (3) begin
         @(negedge clk);
         chk("no_stale_valid", io.out_valid, 0);
      end
      @(posedge clk);
      #1;
      chk("no_stale_count", out_count - base_out, 0);
      send(8'h10, 3'd4, 2'b01, 8'h01);
      io.in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_lat1", io.out_valid, 0);
      @(negedge clk);
      chk("post_rst_lat2", io.out_valid, 0);
      @(negedge clk);
      chk("post_rst_lat3", io.out_valid, 1);
      chk("post_rst_data", io.out_data, 8'h01);
      @(posedge clk);
      #1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
